m_mem_access: RTL and testbench
===============================

Name: m_mem_access

Overview:
- Memory-stage access unit, directly downstream of the E/M pipeline register.
- Consumes the M-stage address, store data and access controls, and runs a req/ack transaction on the external data bus.
- Aligns store data and generates byte enables; sign/zero-extends load data.
- Detects address exceptions and bus timeouts, and stalls the pipeline while a transaction is outstanding.

Parameters:
- TIMEOUT, 16: maximum WAIT cycles before the transaction is abandoned as a bus error.
- DM_TOP, 32'h0000_2FFF: highest valid data-memory byte address.
- TC0_BASE, 32'h0000_7F00: timer0 register window base (12 bytes).
- TC1_BASE, 32'h0000_7F10: timer1 register window base (12 bytes).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- Req  in  1  exception/interrupt flush request from CP0
- M_PC  in  32  PC of the M-stage instruction (forwarded to m_inst_addr)
- M_ALUout  in  32  effective byte address
- M_RD2  in  32  store data
- M_DM_write  in  1  store instruction
- M_DM_read  in  1  load instruction
- M_DMop  in  2  access size: 0 word, 1 half, 2 byte
- M_BEop  in  3  load extend: 0 lw, 1 lbu, 2 lb, 3 lhu, 4 lh
- M_ExcCode  in  5  exception code carried from earlier stages
- m_ack  in  1  bus acknowledge
- m_rdata  in  32  bus read data, valid with m_ack
- m_req  out  1  bus request, registered
- m_wr  out  1  write strobe, registered
- m_addr  out  32  word-aligned bus address (low 2 bits 0), registered
- m_byteen  out  4  byte enables, registered
- m_wdata  out  32  lane-aligned store data, registered
- m_inst_addr  out  32  PC of the requesting instruction, registered
- M_DMout  out  32  extended load result
- M_stall  out  1  freeze F/D/E/M
- M_ExcCode_out  out  5  final M-stage exception code

Behaviour:
- Reset (async, reset=0): state IDLE, counter 0. All outputs 0 except m_byteen=4'b0000.
- Access legality, combinational, evaluated in IDLE:
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Out of range: not in [0, DM_TOP], [TC0_BASE, TC0_BASE+11] or [TC1_BASE, TC1_BASE+11].
  - Non-word access to a timer window is illegal.
  - Store to TC_BASE+8 (count register) is illegal.
  - Illegal load gives code 4 (AdEL); illegal store gives code 5 (AdES).
- start = IDLE & (M_DM_read|M_DM_write) & M_ExcCode==0 & legal & ~Req.
- IDLE:
  - If start: register the bus outputs, set m_req=1, go to WAIT.
  - Otherwise stay in IDLE with m_req=0.
- WAIT:
  - m_req held high; counter increments each cycle.
  - m_ack=1: capture m_rdata, set m_req=0, go to DONE.
  - counter==TIMEOUT-1 with no ack: set m_req=0, set the buserr flag, go to DONE.
- DONE: lasts one cycle, then IDLE. The instruction advances at the end of this cycle.
- M_stall = start | (state==WAIT). It is 0 in DONE and in idle cycles with no access.
- Latency with ack in the first WAIT cycle: 3 cycles, 2 of them stalled.
- Byte enables:
  - Word: 1111.
  - Half: addr[1]=0 gives 0011, addr[1]=1 gives 1100.
  - Byte: 1<<addr[1:0].
  - Load: 1111 with m_wr=0.
- Store data:
  - Half: RD2[15:0] replicated in both halves.
  - Byte: RD2[7:0] replicated in all four lanes.
- M_DMout:
  - In DONE: captured word with the lane selected by the captured addr[1:0], extended per M_BEop.
  - Zero when buserr is set. Zero in all other states.
- M_ExcCode_out, valid when M_stall=0, priority order:
  1. Incoming M_ExcCode if nonzero.
  2. AdEL/AdES.
  3. 7 (DBE) in DONE with buserr.
  4. 0.
- Req:
  - In IDLE, Req suppresses start.
  - In WAIT, Req is ignored. A bus transaction is never abandoned except by timeout or reset.
- m_ack outside WAIT is ignored.
- Reset in WAIT: m_req drops immediately and the captured data is discarded.

Test Plan:
- lw at 0x0000_0010, m_ack one cycle after m_req, m_rdata=0x8765_4321 -> M_stall high 2 cycles; M_DMout=0x8765_4321 in DONE; ExcCode_out=0.
- sh at 0x0000_0006, RD2=0x0000_ABCD -> m_byteen=1100, m_wdata=0xABCD_ABCD, m_addr=0x0000_0004, m_wr=1.
- lb at 0x0000_0003, m_rdata=0x80FF_FF00 -> M_DMout=0xFFFF_FF80. Same access with lbu -> 0x0000_0080.
- lh at 0x0000_0001 -> no m_req, M_stall=0, ExcCode_out=4. sw to 0x0000_7F08 -> ExcCode_out=5.
- lw with m_ack held 0 and TIMEOUT=16 -> m_req high exactly 16 cycles, then DONE with ExcCode_out=7 and M_DMout=0.
- reset pulled low during WAIT -> m_req=0 asynchronously. After release, state is IDLE and a new lw completes normally.

Source files
------------

// File: rtl/m_mem_access_if.sv
// -----------------------------------------------------------------------------
// m_mem_access_if
//   Request/acknowledge data-bus interface between the memory-stage access
//   unit (master) and the data memory / peripheral fabric (slave).
//
//   m_req       master -> slave  bus request, held until acknowledged
//   m_wr        master -> slave  write strobe (1 = store, 0 = load)
//   m_addr      master -> slave  word-aligned byte address
//   m_byteen    master -> slave  byte-lane enables
//   m_wdata     master -> slave  lane-aligned store data
//   m_inst_addr master -> slave  PC of the instruction that issued the access
//   m_ack       slave  -> master transaction complete
//   m_rdata     slave  -> master read data, valid while m_ack is high
// -----------------------------------------------------------------------------
interface m_mem_access_if;
    logic        m_req;
    logic        m_wr;
    logic [31:0] m_addr;
    logic [3:0]  m_byteen;
    logic [31:0] m_wdata;
    logic [31:0] m_inst_addr;
    logic        m_ack;
    logic [31:0] m_rdata;

    modport master (
        output m_req, m_wr, m_addr, m_byteen, m_wdata, m_inst_addr,
        input  m_ack, m_rdata
    );

    modport slave (
        input  m_req, m_wr, m_addr, m_byteen, m_wdata, m_inst_addr,
        output m_ack, m_rdata
    );
endinterface

// File: rtl/m_mem_access.sv
// -----------------------------------------------------------------------------
// m_mem_access
//   Memory-stage access unit sitting directly after the E/M pipeline register.
//   It checks the legality of the M-stage load/store, runs one req/ack
//   transaction on the external data bus, aligns store data into byte lanes,
//   extends load data, reports address / bus-error exceptions and stalls the
//   pipeline while a transaction is outstanding.
//
//   Ports
//     clk            rising-edge clock
//     reset          asynchronous, active-low reset
//     Req            CP0 flush request (suppresses a new access only)
//     M_PC           PC of the M-stage instruction
//     M_ALUout       effective byte address
//     M_RD2          store data
//     M_DM_write     store instruction
//     M_DM_read      load instruction
//     M_DMop         access size: 0 word, 1 half, 2 byte
//     M_BEop         load extension: 0 lw, 1 lbu, 2 lb, 3 lhu, 4 lh
//     M_ExcCode      exception code carried from earlier stages
//     bus            data bus, master side (all outputs registered)
//     M_DMout        extended load result (valid in the DONE cycle)
//     M_stall        freeze F/D/E/M
//     M_ExcCode_out  final M-stage exception code
// -----------------------------------------------------------------------------
module m_mem_access #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] DM_TOP   = 32'h0000_2FFF,
    parameter logic [31:0] TC0_BASE = 32'h0000_7F00,
    parameter logic [31:0] TC1_BASE = 32'h0000_7F10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [31:0] M_PC,
    input  logic [31:0] M_ALUout,
    input  logic [31:0] M_RD2,
    input  logic        M_DM_write,
    input  logic        M_DM_read,
    input  logic [1:0]  M_DMop,
    input  logic [2:0]  M_BEop,
    input  logic [4:0]  M_ExcCode,
    m_mem_access_if.master bus,
    output logic [31:0] M_DMout,
    output logic        M_stall,
    output logic [4:0]  M_ExcCode_out
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t             state_q,     state_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic               req_q,       req_d;
    logic               wr_q,        wr_d;
    logic [31:0]        addr_q,      addr_d;
    logic [3:0]         byteen_q,    byteen_d;
    logic [31:0]        wdata_q,     wdata_d;
    logic [31:0]        inst_addr_q, inst_addr_d;
    logic [31:0]        rdata_q,     rdata_d;
    logic [1:0]         addr_lo_q,   addr_lo_d;
    logic [2:0]         beop_q,      beop_d;
    logic               buserr_q,    buserr_d;

    // -------------------------------------------------------------------------
    // Access decode and legality
    // -------------------------------------------------------------------------
    logic is_word, is_half, is_byte;
    logic access;
    logic in_dm, in_tc0, in_tc1, in_timer;
    logic misaligned, illegal;
    logic addr_exc;
    logic start;

    // Size code 3 is unused by the decoder upstream; it is treated as a word.
    assign is_half = (M_DMop == 2'd1);
    assign is_byte = (M_DMop == 2'd2);
    assign is_word = ~is_half & ~is_byte;
    assign access  = M_DM_read | M_DM_write;

    assign in_dm    = (M_ALUout <= DM_TOP);
    assign in_tc0   = (M_ALUout >= TC0_BASE) && (M_ALUout <= TC0_BASE + 32'd11);
    assign in_tc1   = (M_ALUout >= TC1_BASE) && (M_ALUout <= TC1_BASE + 32'd11);
    assign in_timer = in_tc0 | in_tc1;

    assign misaligned = (is_half & M_ALUout[0]) | (is_word & (|M_ALUout[1:0]));

    // Timer windows accept only word accesses, and their count register
    // (offset 8) is read-only.
    assign illegal = misaligned
                   | ~(in_dm | in_timer)
                   | (in_timer & ~is_word)
                   | (M_DM_write & ((M_ALUout == TC0_BASE + 32'd8) ||
                                    (M_ALUout == TC1_BASE + 32'd8)));

    assign addr_exc = (state_q == S_IDLE) & access & illegal;

    assign start = (state_q == S_IDLE) & access & (M_ExcCode == 5'd0)
                 & ~illegal & ~Req;

    // -------------------------------------------------------------------------
    // Store lane alignment
    // -------------------------------------------------------------------------
    logic [3:0]  byteen_st;
    logic [31:0] wdata_st;

    // NOTE: every signal driven from always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        byteen_st = 4'b1111;
        wdata_st  = M_RD2;
        if (is_half) begin
            byteen_st = M_ALUout[1] ? 4'b1100 : 4'b0011;
            wdata_st  = {2{M_RD2[15:0]}};
        end else if (is_byte) begin
            byteen_st = 4'b0001 << M_ALUout[1:0];
            wdata_st  = {4{M_RD2[7:0]}};
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_d       = req_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        byteen_d    = byteen_q;
        wdata_d     = wdata_q;
        inst_addr_d = inst_addr_q;
        rdata_d     = rdata_q;
        addr_lo_d   = addr_lo_q;
        beop_d      = beop_q;
        buserr_d    = buserr_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_WAIT;
                    cnt_d       = '0;
                    req_d       = 1'b1;
                    wr_d        = M_DM_write;
                    addr_d      = {M_ALUout[31:2], 2'b00};
                    byteen_d    = M_DM_write ? byteen_st : 4'b1111;
                    wdata_d     = wdata_st;
                    inst_addr_d = M_PC;
                    addr_lo_d   = M_ALUout[1:0];
                    beop_d      = M_BEop;
                    rdata_d     = '0;
                    buserr_d    = 1'b0;
                end
            end

            // Req is deliberately not looked at here: once issued, a bus
            // transaction completes or times out, it is never abandoned.
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.m_ack) begin
                    rdata_d = bus.m_rdata;
                    req_d   = 1'b0;
                    wr_d    = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    req_d    = 1'b0;
                    wr_d     = 1'b0;
                    buserr_d = 1'b1;
                    state_d  = S_DONE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_q       <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            byteen_q    <= 4'b0000;
            wdata_q     <= '0;
            inst_addr_q <= '0;
            rdata_q     <= '0;
            addr_lo_q   <= '0;
            beop_q      <= '0;
            buserr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            byteen_q    <= byteen_d;
            wdata_q     <= wdata_d;
            inst_addr_q <= inst_addr_d;
            rdata_q     <= rdata_d;
            addr_lo_q   <= addr_lo_d;
            beop_q      <= beop_d;
            buserr_q    <= buserr_d;
        end
    end

    assign bus.m_req       = req_q;
    assign bus.m_wr        = wr_q;
    assign bus.m_addr      = addr_q;
    assign bus.m_byteen    = byteen_q;
    assign bus.m_wdata     = wdata_q;
    assign bus.m_inst_addr = inst_addr_q;

    // -------------------------------------------------------------------------
    // Load extension
    // -------------------------------------------------------------------------
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        ld_half = addr_lo_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        unique case (addr_lo_q)
            2'd0:    ld_byte = rdata_q[7:0];
            2'd1:    ld_byte = rdata_q[15:8];
            2'd2:    ld_byte = rdata_q[23:16];
            default: ld_byte = rdata_q[31:24];
        endcase

        ld_ext = rdata_q;
        case (beop_q)
            3'd1:    ld_ext = {24'd0, ld_byte};
            3'd2:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'd3:    ld_ext = {16'd0, ld_half};
            3'd4:    ld_ext = {{16{ld_half[15]}}, ld_half};
            default: ld_ext = rdata_q;
        endcase
    end

    // Load data is only presented in the cycle the instruction retires from M.
    assign M_DMout = ((state_q == S_DONE) && !buserr_q) ? ld_ext : 32'd0;

    // -------------------------------------------------------------------------
    // Stall and exception reporting
    // -------------------------------------------------------------------------
    assign M_stall = start | (state_q == S_WAIT);

    always_comb begin
        M_ExcCode_out = 5'd0;
        if (M_ExcCode != 5'd0) begin
            M_ExcCode_out = M_ExcCode;
        end else if (addr_exc) begin
            M_ExcCode_out = M_DM_write ? EXC_ADES : EXC_ADEL;
        end else if ((state_q == S_DONE) && buserr_q) begin
            M_ExcCode_out = EXC_DBE;
        end
    end

endmodule

// File: tb/tb_m_mem_access.sv
// -----------------------------------------------------------------------------
// tb_m_mem_access
//   Self-checking bench for m_mem_access. The bench acts as CPU pipeline and
//   as bus slave; expected values come from a behavioural model written in
//   terms of address ranges, lane arithmetic and transaction timing.
// -----------------------------------------------------------------------------
module tb_m_mem_access;

    localparam int TIMEOUT = 16;

    logic        clk;
    logic        reset;
    logic        Req;
    logic [31:0] M_PC;
    logic [31:0] M_ALUout;
    logic [31:0] M_RD2;
    logic        M_DM_write;
    logic        M_DM_read;
    logic [1:0]  M_DMop;
    logic [2:0]  M_BEop;
    logic [4:0]  M_ExcCode;
    logic [31:0] M_DMout;
    logic        M_stall;
    logic [4:0]  M_ExcCode_out;

    int tests_run = 0;
    int tests_failed = 0;

    m_mem_access_if bus ();

    m_mem_access #(
        .TIMEOUT  (TIMEOUT),
        .DM_TOP   (32'h0000_2FFF),
        .TC0_BASE (32'h0000_7F00),
        .TC1_BASE (32'h0000_7F10)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .Req           (Req),
        .M_PC          (M_PC),
        .M_ALUout      (M_ALUout),
        .M_RD2         (M_RD2),
        .M_DM_write    (M_DM_write),
        .M_DM_read     (M_DM_read),
        .M_DMop        (M_DMop),
        .M_BEop        (M_BEop),
        .M_ExcCode     (M_ExcCode),
        .bus           (bus),
        .M_DMout       (M_DMout),
        .M_stall       (M_stall),
        .M_ExcCode_out (M_ExcCode_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    function automatic int ref_size(input logic [1:0] dmop);
        if (dmop == 2'd1) return 2;
        if (dmop == 2'd2) return 1;
        return 4;
    endfunction

    function automatic bit ref_legal(input bit wr, input logic [1:0] dmop,
                                     input logic [31:0] a);
        int  sz;
        bit  dm, t0, t1;
        sz = ref_size(dmop);
        dm = (a <= 32'h2FFF);
        t0 = (a >= 32'h7F00) && (a < 32'h7F0C);
        t1 = (a >= 32'h7F10) && (a < 32'h7F1C);
        if ((a % sz) != 0) return 1'b0;
        if (!(dm || t0 || t1)) return 1'b0;
        if ((t0 || t1) && sz != 4) return 1'b0;
        if (wr && (a == 32'h7F08 || a == 32'h7F18)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [3:0] ref_byteen(input bit wr, input logic [1:0] dmop,
                                              input logic [31:0] a);
        int sz;
        sz = ref_size(dmop);
        if (!wr || sz == 4) return 4'b1111;
        if (sz == 2) return 4'(4'b0011 << (a % 4));
        return 4'(4'b0001 << (a % 4));
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] dmop, input logic [31:0] d);
        int sz;
        sz = ref_size(dmop);
        if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
        if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] beop, input logic [31:0] a,
                                             input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (16 * ((a % 4) / 2))) & 32'hFFFF;
        case (beop)
            3'd1:    return b;
            3'd2:    return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
            3'd3:    return h;
            3'd4:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            default: return w;
        endcase
    endfunction

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    task automatic idle_inputs();
        Req        = 1'b0;
        M_PC       = 32'd0;
        M_ALUout   = 32'd0;
        M_RD2      = 32'd0;
        M_DM_write = 1'b0;
        M_DM_read  = 1'b0;
        M_DMop     = 2'd0;
        M_BEop     = 3'd0;
        M_ExcCode  = 5'd0;
        bus.m_ack  = 1'b0;
        bus.m_rdata = 32'd0;
    endtask

    // One complete M-stage access. Called at posedge+1 with the DUT in IDLE;
    // returns at posedge+1 with the DUT back in IDLE. ack_delay >= TIMEOUT
    // means the slave never answers.
    task automatic run_access(input string tag, input bit wr, input logic [1:0] dmop,
                              input logic [2:0] beop, input logic [31:0] a,
                              input logic [31:0] rd2, input logic [31:0] rdata,
                              input logic [4:0] exc_in, input bit flush,
                              input int ack_delay);
        bit          legal, go, timed_out;
        logic [4:0]  exp_exc;
        logic [31:0] pc;
        int          req_cycles, stall_cycles, exp_req;

        legal   = ref_legal(wr, dmop, a);
        go      = legal && exc_in == 5'd0 && !flush;
        exp_exc = (exc_in != 5'd0) ? exc_in : (!legal ? (wr ? 5'd5 : 5'd4) : 5'd0);
        pc      = {$urandom_range(0, 32'h3FFF), 2'b00};

        M_DM_write = wr;
        M_DM_read  = !wr;
        M_DMop     = dmop;
        M_BEop     = beop;
        M_ALUout   = a;
        M_RD2      = rd2;
        M_PC       = pc;
        M_ExcCode  = exc_in;
        Req        = flush;

        @(negedge clk);
        tests_run++;
        if (M_stall !== go) begin
            tests_failed++;
            $display("FAIL %s start_stall: got %b expected %b", tag, M_stall, go);
        end

        if (!go) begin
            tests_run++;
            if (M_ExcCode_out !== exp_exc) begin
                tests_failed++;
                $display("FAIL %s exc_no_access: got %0d expected %0d", tag, M_ExcCode_out, exp_exc);
            end
            @(posedge clk); #1;
            tests_run++;
            if (bus.m_req !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s no_req: got %b expected 0", tag, bus.m_req);
            end
            idle_inputs();
            return;
        end

        stall_cycles = 1;
        req_cycles   = 0;
        @(posedge clk); #1;

        tests_run++;
        if (bus.m_req !== 1'b1 || bus.m_wr !== wr || bus.m_addr !== (a & 32'hFFFF_FFFC) ||
            bus.m_byteen !== ref_byteen(wr, dmop, a) || bus.m_inst_addr !== pc ||
            (wr && bus.m_wdata !== ref_wdata(dmop, rd2))) begin
            tests_failed++;
            $display("FAIL %s bus_fields: got req=%b wr=%b addr=%h be=%b wd=%h pc=%h expected req=1 wr=%b addr=%h be=%b wd=%h pc=%h",
                     tag, bus.m_req, bus.m_wr, bus.m_addr, bus.m_byteen, bus.m_wdata, bus.m_inst_addr,
                     wr, a & 32'hFFFF_FFFC, ref_byteen(wr, dmop, a), ref_wdata(dmop, rd2), pc);
        end

        // Slave side: answer after ack_delay WAIT cycles. Req toggles randomly
        // during WAIT and must have no effect.
        while (bus.m_req === 1'b1 && req_cycles < TIMEOUT + 4) begin
            bus.m_ack   = (req_cycles == ack_delay);
            bus.m_rdata = bus.m_ack ? rdata : $urandom();
            Req         = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (M_stall === 1'b1) stall_cycles++;
            req_cycles++;
            @(posedge clk); #1;
        end
        bus.m_ack   = 1'b0;
        bus.m_rdata = $urandom();
        Req         = 1'b0;

        timed_out = (ack_delay >= TIMEOUT);
        exp_req   = timed_out ? TIMEOUT : ack_delay + 1;

        tests_run++;
        if (req_cycles != exp_req) begin
            tests_failed++;
            $display("FAIL %s req_cycles: got %0d expected %0d", tag, req_cycles, exp_req);
        end
        tests_run++;
        if (stall_cycles != exp_req + 1) begin
            tests_failed++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", tag, stall_cycles, exp_req + 1);
        end

        @(negedge clk);
        tests_run++;
        if (M_stall !== 1'b0 || M_DMout !== (timed_out ? 32'd0 : ref_load(beop, a, rdata)) ||
            M_ExcCode_out !== (timed_out ? 5'd7 : 5'd0)) begin
            tests_failed++;
            $display("FAIL %s done_cycle: got stall=%b dmout=%h exc=%0d expected stall=0 dmout=%h exc=%0d",
                     tag, M_stall, M_DMout, M_ExcCode_out,
                     timed_out ? 32'd0 : ref_load(beop, a, rdata), timed_out ? 7 : 0);
        end

        @(posedge clk); #1;
        idle_inputs();
        tests_run++;
        if (M_DMout !== 32'd0 || bus.m_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s back_to_idle: got dmout=%h req=%b expected 0/0", tag, M_DMout, bus.m_req);
        end
    endtask

    // -------------------------------------------------------------------------
    // Scenarios
    // -------------------------------------------------------------------------
    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (bus.m_req !== 1'b0 || bus.m_wr !== 1'b0 || bus.m_addr !== 32'd0 ||
            bus.m_byteen !== 4'b0000 || bus.m_wdata !== 32'd0 || bus.m_inst_addr !== 32'd0 ||
            M_DMout !== 32'd0 || M_stall !== 1'b0 || M_ExcCode_out !== 5'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got req=%b wr=%b addr=%h be=%b wd=%h pc=%h dmout=%h stall=%b exc=%0d expected all zero",
                     bus.m_req, bus.m_wr, bus.m_addr, bus.m_byteen, bus.m_wdata, bus.m_inst_addr,
                     M_DMout, M_stall, M_ExcCode_out);
        end
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        run_access("lw_basic",  1'b0, 2'd0, 3'd0, 32'h0000_0010, 32'd0,         32'h8765_4321, 5'd0, 1'b0, 0);
        run_access("sh_upper",  1'b1, 2'd1, 3'd0, 32'h0000_0006, 32'h0000_ABCD, 32'd0,         5'd0, 1'b0, 1);
        run_access("lb_sign",   1'b0, 2'd2, 3'd2, 32'h0000_0003, 32'd0,         32'h80FF_FF00, 5'd0, 1'b0, 0);
        run_access("lbu_zero",  1'b0, 2'd2, 3'd1, 32'h0000_0003, 32'd0,         32'h80FF_FF00, 5'd0, 1'b0, 2);
        run_access("lh_hi",     1'b0, 2'd1, 3'd4, 32'h0000_0102, 32'd0,         32'h9234_5678, 5'd0, 1'b0, 0);
        run_access("sb_lane1",  1'b1, 2'd2, 3'd0, 32'h0000_2FFD, 32'h1234_56A5, 32'd0,         5'd0, 1'b0, 0);
        run_access("lw_dm_top", 1'b0, 2'd0, 3'd0, 32'h0000_2FFC, 32'd0,         32'hCAFE_F00D, 5'd0, 1'b0, 3);
        run_access("lw_tc0_cnt",1'b0, 2'd0, 3'd0, 32'h0000_7F08, 32'd0,         32'h0000_0042, 5'd0, 1'b0, 0);
        run_access("sw_tc1",    1'b1, 2'd0, 3'd0, 32'h0000_7F14, 32'h5555_AAAA, 32'd0,         5'd0, 1'b0, 0);
    endtask

    task automatic test_exceptions();
        run_access("lh_misalign",  1'b0, 2'd1, 3'd4, 32'h0000_0001, 32'd0, 32'd0, 5'd0, 1'b0, 0);
        run_access("sw_tc0_count", 1'b1, 2'd0, 3'd0, 32'h0000_7F08, 32'd0, 32'd0, 5'd0, 1'b0, 0);
        run_access("sw_tc1_count", 1'b1, 2'd0, 3'd0, 32'h0000_7F18, 32'd0, 32'd0, 5'd0, 1'b0, 0);
        run_access("lb_timer",     1'b0, 2'd2, 3'd2, 32'h0000_7F00, 32'd0, 32'd0, 5'd0, 1'b0, 0);
        run_access("lw_past_dm",   1'b0, 2'd0, 3'd0, 32'h0000_3000, 32'd0, 32'd0, 5'd0, 1'b0, 0);
        run_access("lw_past_tc0",  1'b0, 2'd0, 3'd0, 32'h0000_7F0C, 32'd0, 32'd0, 5'd0, 1'b0, 0);
        run_access("sw_misalign",  1'b1, 2'd0, 3'd0, 32'h0000_0012, 32'd0, 32'd0, 5'd0, 1'b0, 0);
        run_access("exc_in_wins",  1'b0, 2'd1, 3'd3, 32'h0000_0001, 32'd0, 32'd0, 5'd10, 1'b0, 0);
        run_access("exc_in_legal", 1'b0, 2'd0, 3'd0, 32'h0000_0020, 32'd0, 32'd0, 5'd12, 1'b0, 0);
        run_access("req_flush",    1'b1, 2'd0, 3'd0, 32'h0000_0020, 32'd0, 32'd0, 5'd0,  1'b1, 0);
    endtask

    task automatic test_timeout();
        run_access("lw_timeout", 1'b0, 2'd0, 3'd0, 32'h0000_0040, 32'd0, 32'h1111_2222, 5'd0, 1'b0, TIMEOUT);
        run_access("lw_ack_last", 1'b0, 2'd0, 3'd0, 32'h0000_0044, 32'd0, 32'h3333_4444, 5'd0, 1'b0, TIMEOUT - 1);
    endtask

    task automatic test_ack_outside_wait();
        idle_inputs();
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        tests_run++;
        if (M_DMout !== 32'd0 || M_stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_ack: got dmout=%h stall=%b expected 0/0", M_DMout, M_stall);
        end
        @(posedge clk); #1;
        tests_run++;
        if (bus.m_req !== 1'b0 || M_DMout !== 32'd0) begin
            tests_failed++;
            $display("FAIL idle_ack_after: got req=%b dmout=%h expected 0/0", bus.m_req, M_DMout);
        end
        idle_inputs();
    endtask

    task automatic test_reset_in_wait();
        M_DM_read = 1'b1;
        M_DMop    = 2'd0;
        M_ALUout  = 32'h0000_0080;
        M_PC      = 32'h0000_3000;
        @(posedge clk); #1;
        @(posedge clk); #2;
        tests_run++;
        if (bus.m_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_wait_pre: got req=%b expected 1", bus.m_req);
        end
        idle_inputs();
        reset = 1'b0;
        #1;
        tests_run++;
        if (bus.m_req !== 1'b0 || bus.m_addr !== 32'd0 || bus.m_byteen !== 4'b0000 ||
            M_stall !== 1'b0 || M_DMout !== 32'd0) begin
            tests_failed++;
            $display("FAIL rst_wait_async: got req=%b addr=%h be=%b stall=%b dmout=%h expected all zero",
                     bus.m_req, bus.m_addr, bus.m_byteen, M_stall, M_DMout);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        run_access("lw_after_rst", 1'b0, 2'd0, 3'd0, 32'h0000_0080, 32'd0, 32'h0BAD_F00D, 5'd0, 1'b0, 1);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [1:0]  dmop;
        logic [2:0]  beop;
        bit          wr;
        int          kind, region, dly;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 7);
            wr   = (kind >= 5);
            case (kind)
                0: begin dmop = 2'd0; beop = 3'd0; end
                1: begin dmop = 2'd1; beop = 3'd3; end
                2: begin dmop = 2'd1; beop = 3'd4; end
                3: begin dmop = 2'd2; beop = 3'd1; end
                4: begin dmop = 2'd2; beop = 3'd2; end
                5: begin dmop = 2'd0; beop = 3'd0; end
                6: begin dmop = 2'd1; beop = 3'd0; end
                default: begin dmop = 2'd2; beop = 3'd0; end
            endcase
            region = $urandom_range(0, 9);
            if (region < 6)      a = $urandom_range(0, 32'h2FFF);
            else if (region < 8) a = 32'h7F00 + $urandom_range(0, 31);
            else                 a = $urandom_range(32'h2FF0, 32'h3010);
            // Keep most accesses aligned so that the bus path is well exercised.
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(ref_size(dmop)) - 32'd1);
            dly = ($urandom_range(0, 9) == 0) ? TIMEOUT : $urandom_range(0, 5);
            run_access($sformatf("rand%0d", i), wr, dmop, beop, a, $urandom(), $urandom(),
                       5'd0, 1'b0, dly);
        end
    endtask

    // -------------------------------------------------------------------------
    // Sequence
    // -------------------------------------------------------------------------
    initial begin
        idle_inputs();
        reset = 1'b1;
        test_reset();
        test_directed();
        test_exceptions();
        test_timeout();
        test_ack_outside_wait();
        test_reset_in_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Backstop so the run always ends by itself.
    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
